data_sram_ctrl: RTL and testbench
=================================

DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 Parameter OUTSTANDING_DEPTH, default 2, max requests accepted by the bus and not yet acked by the MEM stage; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous reset, active-low.
REQ-004 es_req_valid  input  1  EX stage holds a load/store needing data memory.
REQ-005 es_req_wr  input  1  1 = store, 0 = load.
REQ-006 es_req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
REQ-007 es_req_addr  input  32  byte address.
REQ-008 es_req_wdata  input  32  store data, right-aligned.
REQ-009 es_req_ready  output  1  request accepted by the bus this cycle.
REQ-010 flush  input  1  exception/ertn pipeline flush.
REQ-011 ms_resp_valid  output  1  head response available to the MEM stage.
REQ-012 ms_resp_rdata  output  32  head response read data (raw word; MEM stage extracts and extends it).
REQ-013 ms_resp_ack  input  1  MEM stage consumes the head response.
REQ-014 ms_wait  output  1  at least one request issued whose data_ok has not yet returned.
REQ-015 data_sram_req, data_sram_wr  output  1 each  bus request and its direction.
REQ-016 data_sram_size  output  2  same encoding as es_req_size.
REQ-017 data_sram_wstrb  output  4  byte enables.
REQ-018 data_sram_addr, data_sram_wdata  output  32 each  bus address and lane-replicated write data.
REQ-019 data_sram_addr_ok, data_sram_data_ok  input  1 each  address and data handshakes.
REQ-020 data_sram_rdata  input  32  bus read data, valid with data_ok.

Function
REQ-021 Credit counter cnt (0..OUTSTANDING_DEPTH) shall increment on req&addr_ok, decrement on ms_resp_ack&ms_resp_valid, and stay unchanged when both occur in the same cycle.
REQ-022 data_sram_req shall be es_req_valid & (cnt<OUTSTANDING_DEPTH) & ~flush; es_req_ready shall be data_sram_req & data_sram_addr_ok.
REQ-023 addr, wr and size shall pass through combinationally, with zero added latency.
REQ-024 wstrb: load gives 0000; byte gives 0001<<addr[1:0]; half gives 1100 when addr[1]=1, else 0011; word gives 1111.
REQ-025 wdata: byte gives {4{wdata[7:0]}}; half gives {2{wdata[15:0]}}; word passes unchanged.
REQ-026 In-flight counter inf shall increment on the addr handshake and decrement on data_ok, with simultaneous events leaving it unchanged; ms_wait = (inf!=0).
REQ-027 Each non-discarded data_ok shall push data_sram_rdata into a response FIFO of OUTSTANDING_DEPTH entries; store responses shall also be pushed, with rdata don't-care.
REQ-028 ms_resp_valid/ms_resp_rdata shall come from the FIFO head, registered, so the first response is visible the cycle after data_ok.
REQ-029 The FIFO shall never overflow, because credits cover unacked entries; a data_ok with inf=0 shall be ignored and inf shall not underflow.
REQ-030 An ack with FIFO empty shall be ignored; FIFO pointers shall wrap modulo OUTSTANDING_DEPTH.

Reset
REQ-031 While resetn=0 at a clock edge: cnt, inf, discard counter and FIFO pointers shall be 0; data_sram_req=0, es_req_ready=0, ms_resp_valid=0, ms_wait=0, ms_resp_rdata=0.
REQ-032 A reset in mid-transaction shall drop all in-flight and buffered responses without emitting any.

Configuration
REQ-033 Macro DSRAM_CANCEL_EN, when defined, makes flush copy inf into discard counter dcnt, empty the FIFO and set cnt to inf.
REQ-034 With DSRAM_CANCEL_EN, each later data_ok shall decrement dcnt and be dropped, without a FIFO push, while dcnt!=0; it shall also decrement inf and cnt.
REQ-035 With DSRAM_CANCEL_EN, new requests are allowed during discard; an addr handshake in the flush cycle cannot occur because flush gates req.
REQ-036 Without DSRAM_CANCEL_EN, flush shall only gate data_sram_req, and every response shall be delivered.

Verification
REQ-037 Byte store to addr 0x1003 with wdata 0x000000AB gives wstrb=1000, wdata=0xABABABAB; half store to 0x1002 gives wstrb=1100.
REQ-038 Two loads with addr_ok=1 each cycle and no ack: third request gives req=0 with cnt=2; ack in the same cycle as the third request's attempt gives req=1 the next cycle.
REQ-039 data_ok delivers 0x12345678 and 0x9ABCDEF0 on back-to-back cycles: responses appear in order, one cycle later each, and are held until acked.
REQ-040 DSRAM_CANCEL_EN, two loads in flight, then flush: next two data_ok produce no ms_resp_valid; a subsequent load's data 0x55 is delivered.
REQ-041 resetn low with 2 in flight: outputs are 0 next cycle, and late data_ok pulses are ignored.

Source files
------------

// File: rtl/data_sram_ctrl_if.sv
// Data SRAM bus: request channel with addr_ok/data_ok handshakes.
// The controller drives the master side, the memory the slave side.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_ctrl.sv
// EX/MEM data-memory bridge: credit-limited issue, in-order response FIFO.
// Optional DSRAM_CANCEL_EN: flush discards responses still in flight.
module data_sram_ctrl #(
  parameter int OUTSTANDING_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_req_valid,
  input  logic        es_req_wr,
  input  logic [1:0]  es_req_size,
  input  logic [31:0] es_req_addr,
  input  logic [31:0] es_req_wdata,
  output logic        es_req_ready,
  input  logic        flush,
  output logic        ms_resp_valid,
  output logic [31:0] ms_resp_rdata,
  input  logic        ms_resp_ack,
  output logic        ms_wait,
  data_sram_if.master data_sram
);
  localparam int D  = OUTSTANDING_DEPTH;
  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  typedef logic [CW-1:0] cnt_t;

  cnt_t            cnt, inf, fcnt, dcnt;
  logic [PW-1:0]   wptr, rptr;
  logic [31:0]     mem [D];
  logic            hs, dok, ack_v, push, discard, cancel;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue is gated by reset too so the bus sees no request during reset.
  assign data_sram.req   = resetn & es_req_valid & (cnt < cnt_t'(D)) & ~flush;
  assign data_sram.wr    = es_req_wr;
  assign data_sram.size  = es_req_size;
  assign data_sram.addr  = es_req_addr;
  assign hs              = data_sram.req & data_sram.addr_ok;
  assign es_req_ready    = hs;

  always_comb begin
    data_sram.wstrb = 4'b1111;
    data_sram.wdata = es_req_wdata;
    case (es_req_size)
      2'd0: begin
        data_sram.wstrb = 4'b0001 << es_req_addr[1:0];
        data_sram.wdata = {4{es_req_wdata[7:0]}};
      end
      2'd1: begin
        data_sram.wstrb = es_req_addr[1] ? 4'b1100 : 4'b0011;
        data_sram.wdata = {2{es_req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!es_req_wr) data_sram.wstrb = 4'b0000;
  end

  assign dok           = data_sram.data_ok & (inf != '0);
  assign ms_resp_valid = (fcnt != '0);
  assign ms_resp_rdata = ms_resp_valid ? mem[rptr] : '0;
  assign ack_v         = ms_resp_ack & ms_resp_valid;
  assign ms_wait       = (inf != '0);

`ifdef DSRAM_CANCEL_EN
  assign cancel  = flush;
  assign discard = dok & (dcnt != '0);

  always_ff @(posedge clk) begin
    if (!resetn)     dcnt <= '0;
    else if (cancel) dcnt <= inf - cnt_t'(dok);
    else             dcnt <= dcnt - cnt_t'(discard);
  end
`else
  assign cancel  = 1'b0;
  assign discard = 1'b0;
  assign dcnt    = '0;
`endif

  assign push = dok & ~discard & ~cancel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      inf  <= '0;
      fcnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else if (cancel) begin
      // Buffered responses are dropped; only in-flight requests keep credits.
      inf  <= inf - cnt_t'(dok);
      cnt  <= inf - cnt_t'(dok);
      fcnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      inf  <= inf + cnt_t'(hs) - cnt_t'(dok);
      cnt  <= cnt + cnt_t'(hs) - cnt_t'(ack_v) - cnt_t'(discard);
      fcnt <= fcnt + cnt_t'(push) - cnt_t'(ack_v);
      if (push)  wptr <= nxt(wptr);
      if (ack_v) rptr <= nxt(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_sram.rdata;
  end
endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl; expectations are hand-computed.
// Define DSRAM_CANCEL_EN for both RTL and bench to exercise cancel.
module tb_data_sram_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        es_req_valid, es_req_wr, es_req_ready, flush;
  logic [1:0]  es_req_size;
  logic [31:0] es_req_addr, es_req_wdata, ms_resp_rdata;
  logic        ms_resp_valid, ms_resp_ack, ms_wait;
  int          vectors = 0;
  int          miscompares = 0;

  data_sram_if bus ();

  data_sram_ctrl #(.OUTSTANDING_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .es_req_valid(es_req_valid), .es_req_wr(es_req_wr), .es_req_size(es_req_size),
    .es_req_addr(es_req_addr), .es_req_wdata(es_req_wdata), .es_req_ready(es_req_ready),
    .flush(flush), .ms_resp_valid(ms_resp_valid), .ms_resp_rdata(ms_resp_rdata),
    .ms_resp_ack(ms_resp_ack), .ms_wait(ms_wait), .data_sram(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; es_req_valid = 1'b1; es_req_wr = 1'b0; es_req_size = 2'd2;
    es_req_addr = '0; es_req_wdata = '0; flush = 1'b0; ms_resp_ack = 1'b0;
    bus.addr_ok = 1'b1; bus.data_ok = 1'b0; bus.rdata = '0;
    tick; tick;
    chk("rst_req", bus.req, 0);
    chk("rst_ready", es_req_ready, 0);
    chk("rst_valid", ms_resp_valid, 0);
    chk("rst_wait", ms_wait, 0);
    chk("rst_rdata", ms_resp_rdata, 0);
    resetn = 1'b1; es_req_valid = 1'b0; bus.addr_ok = 1'b0;
    tick;

    // store formatting, addr_ok held low so nothing issues
    es_req_valid = 1'b1; es_req_wr = 1'b1; es_req_size = 2'd0;
    es_req_addr = 32'h1003; es_req_wdata = 32'h0000_00AB; #1;
    chk("sb_wstrb", bus.wstrb, 4'b1000);
    chk("sb_wdata", bus.wdata, 32'hABAB_ABAB);
    chk("sb_req", bus.req, 1);
    chk("sb_addr", bus.addr, 32'h1003);
    chk("sb_ready", es_req_ready, 0);
    tick;
    es_req_size = 2'd1; es_req_addr = 32'h1002; es_req_wdata = 32'h1234_CDEF; #1;
    chk("sh_hi_wstrb", bus.wstrb, 4'b1100);
    chk("sh_wdata", bus.wdata, 32'hCDEF_CDEF);
    es_req_addr = 32'h1000; #1;
    chk("sh_lo_wstrb", bus.wstrb, 4'b0011);
    es_req_size = 2'd0; es_req_addr = 32'h1001; #1;
    chk("sb1_wstrb", bus.wstrb, 4'b0010);
    tick;
    es_req_size = 2'd3; es_req_addr = 32'h1000; #1;
    chk("s3_wstrb", bus.wstrb, 4'b1111);
    chk("s3_wdata", bus.wdata, 32'h1234_CDEF);
    chk("s3_size", bus.size, 2'd3);
    es_req_wr = 1'b0; es_req_size = 2'd2; #1;
    chk("ld_wstrb", bus.wstrb, 4'b0000);
    chk("ld_wr", bus.wr, 0);
    flush = 1'b1; #1;
    chk("flush_gate", bus.req, 0);
    flush = 1'b0;
    tick;

    // credit limit and in-order responses
    es_req_addr = 32'h2000; bus.addr_ok = 1'b1; #1;
    chk("ld0_ready", es_req_ready, 1);
    tick;
    chk("wait_1", ms_wait, 1);
    chk("ld1_ready", es_req_ready, 1);
    tick;
    chk("cnt_full", bus.req, 0);
    es_req_valid = 1'b0; bus.addr_ok = 1'b0;
    bus.data_ok = 1'b1; bus.rdata = 32'h1234_5678;
    tick;
    chk("r0_valid", ms_resp_valid, 1);
    chk("r0_data", ms_resp_rdata, 32'h1234_5678);
    chk("r0_wait", ms_wait, 1);
    bus.rdata = 32'h9ABC_DEF0;
    tick;
    bus.data_ok = 1'b0;
    chk("r0_held", ms_resp_rdata, 32'h1234_5678);
    chk("wait_0", ms_wait, 0);
    tick;
    chk("r0_held2", ms_resp_rdata, 32'h1234_5678);
    es_req_valid = 1'b1; bus.addr_ok = 1'b1; es_req_addr = 32'h2008; #1;
    chk("third_blocked", bus.req, 0);
    ms_resp_ack = 1'b1;
    tick;
    ms_resp_ack = 1'b0; #1;
    chk("r1_data", ms_resp_rdata, 32'h9ABC_DEF0);
    chk("third_req", bus.req, 1);
    tick;
    es_req_valid = 1'b0; bus.addr_ok = 1'b0;
    chk("third_wait", ms_wait, 1);
    ms_resp_ack = 1'b1;
    tick;
    chk("r1_acked", ms_resp_valid, 0);
    tick;
    ms_resp_ack = 1'b0;
    chk("empty_ack", ms_resp_valid, 0);
    bus.data_ok = 1'b1; bus.rdata = 32'h55;
    tick;
    bus.data_ok = 1'b0;
    chk("r2_valid", ms_resp_valid, 1);
    chk("r2_data", ms_resp_rdata, 32'h55);
    chk("r2_wait", ms_wait, 0);
    // cnt must still be 1 here: one more issue fills it
    es_req_valid = 1'b1; bus.addr_ok = 1'b1; #1;
    chk("cnt1_req", bus.req, 1);
    tick;
    es_req_valid = 1'b0; bus.addr_ok = 1'b0; #1;
    es_req_valid = 1'b1; #1;
    chk("cnt2_after_empty_ack", bus.req, 0);
    es_req_valid = 1'b0; ms_resp_ack = 1'b1;
    tick;
    ms_resp_ack = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h66;
    tick;
    bus.data_ok = 1'b0;
    chk("r3_data", ms_resp_rdata, 32'h66);
    ms_resp_ack = 1'b1;
    tick;
    ms_resp_ack = 1'b0;
    chk("drain_valid", ms_resp_valid, 0);
    chk("drain_wait", ms_wait, 0);

    // flush with two loads in flight
    es_req_valid = 1'b1; bus.addr_ok = 1'b1; es_req_addr = 32'h3000;
    tick; tick;
    es_req_valid = 1'b0; bus.addr_ok = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hA1;
    tick;
`ifdef DSRAM_CANCEL_EN
    chk("cx_drop0", ms_resp_valid, 0);
    bus.rdata = 32'hA2;
    tick;
    bus.data_ok = 1'b0;
    chk("cx_drop1", ms_resp_valid, 0);
    chk("cx_wait", ms_wait, 0);
    es_req_valid = 1'b1; bus.addr_ok = 1'b1;
    tick;
    es_req_valid = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h55;
    tick;
    bus.data_ok = 1'b0;
    chk("cx_new_valid", ms_resp_valid, 1);
    chk("cx_new_data", ms_resp_rdata, 32'h55);
    ms_resp_ack = 1'b1;
    tick;
    ms_resp_ack = 1'b0;
`else
    chk("fl_r0", ms_resp_rdata, 32'hA1);
    bus.rdata = 32'hA2;
    tick;
    bus.data_ok = 1'b0;
    chk("fl_r0_held", ms_resp_rdata, 32'hA1);
    chk("fl_wait", ms_wait, 0);
    ms_resp_ack = 1'b1;
    tick;
    chk("fl_r1", ms_resp_rdata, 32'hA2);
    tick;
    ms_resp_ack = 1'b0;
`endif
    chk("fl_drained", ms_resp_valid, 0);

    // reset with one buffered and one in-flight response
    es_req_valid = 1'b1; bus.addr_ok = 1'b1; es_req_addr = 32'h4000;
    tick; tick;
    es_req_valid = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h77;
    tick;
    bus.data_ok = 1'b0;
    chk("pre_rst_valid", ms_resp_valid, 1);
    resetn = 1'b0; es_req_valid = 1'b1; #1;
    chk("mid_rst_req", bus.req, 0);
    tick;
    chk("mid_rst_valid", ms_resp_valid, 0);
    chk("mid_rst_rdata", ms_resp_rdata, 0);
    chk("mid_rst_wait", ms_wait, 0);
    chk("mid_rst_ready", es_req_ready, 0);
    resetn = 1'b1; es_req_valid = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h88;
    tick; tick;
    bus.data_ok = 1'b0;
    chk("late_dok_valid", ms_resp_valid, 0);
    chk("late_dok_wait", ms_wait, 0);
    es_req_valid = 1'b1; #1;
    chk("post_rst_req", bus.req, 1);
    es_req_valid = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
